// File: rtl/lock_controller_if.sv
// Signal bundle between the keypad/comparator front end and the lock controller.
// The master side drives the user inputs and the slave side reports the lock status.
interface lock_controller_if #(
  parameter int CNT_W   = 4,
  parameter int TIMER_W = 16
);
  logic               power_on;
  logic               star;
  logic               change_req;
  logic               code_ok;
  logic               clear;
  logic [2:0]         state;
  logic [CNT_W-1:0]   wrong_cnt;
  logic [TIMER_W-1:0] timer;
  logic               unlock;
  logic               alarm;

  modport master (
    output power_on, star, change_req, code_ok, clear,
    input  state, wrong_cnt, timer, unlock, alarm
  );

  modport slave (
    input  power_on, star, change_req, code_ok, clear,
    output state, wrong_cnt, timer, unlock, alarm
  );
endinterface

// File: rtl/lock_controller.sv
// Tick-sampled door-lock state machine with a retry limit, a timed lockout that
// releases on its own, and an auto-relock timeout after a successful unlock.
module lock_controller #(
  parameter int TICK_DIV   = 50000,
  parameter int MAX_TRIES  = 3,
  parameter int CNT_W      = 4,
  parameter int OPEN_TICKS = 100,
  parameter int LOCK_TICKS = 600,
  parameter int TIMER_W    = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  lock_controller_if.slave bus
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST    = DIV_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX     = CNT_W'(MAX_TRIES);
  localparam logic [CNT_W-1:0]   CNT_RELEASE = CNT_W'(MAX_TRIES - 1);
  localparam logic [TIMER_W-1:0] T_OPEN      = TIMER_W'(OPEN_TICKS);
  localparam logic [TIMER_W-1:0] T_LOCK      = TIMER_W'(LOCK_TICKS);
  localparam logic [TIMER_W-1:0] T_ONE       = TIMER_W'(1);

  typedef enum logic [2:0] {
    S_OFF     = 3'b000,
    S_ARMED   = 3'b001,
    S_RETRY   = 3'b010,
    S_OPEN    = 3'b100,
    S_CHANGE  = 3'b101,
    S_LOCKOUT = 3'b111
  } state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   wrong_cnt_reg, wrong_cnt_next;
  logic [TIMER_W-1:0] timer_reg, timer_next;
  logic [DIV_W-1:0]   div_reg;
  logic               star_q_reg, chg_q_reg;
  logic               unlock_reg, alarm_reg;
  logic               tick, star_edge, chg_edge;
  logic [CNT_W-1:0]   cnt_inc;

  assign tick      = (div_reg == DIV_LAST);
  assign star_edge = bus.star & ~star_q_reg;
  assign chg_edge  = bus.change_req & ~chg_q_reg;
  // Saturating increment keeps wrong_cnt bounded even from a corrupted count.
  assign cnt_inc   = (wrong_cnt_reg >= CNT_MAX) ? CNT_MAX : wrong_cnt_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_reg       <= '0;
      state_reg     <= S_OFF;
      wrong_cnt_reg <= '0;
      timer_reg     <= '0;
      star_q_reg    <= 1'b0;
      chg_q_reg     <= 1'b0;
      unlock_reg    <= 1'b0;
      alarm_reg     <= 1'b0;
    end else begin
      div_reg <= tick ? '0 : div_reg + DIV_W'(1);
      if (tick) begin
        state_reg     <= state_next;
        wrong_cnt_reg <= wrong_cnt_next;
        timer_reg     <= timer_next;
        star_q_reg    <= bus.star;
        chg_q_reg     <= bus.change_req;
        unlock_reg    <= (state_next == S_OPEN);
        alarm_reg     <= (state_next == S_LOCKOUT);
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    wrong_cnt_next = wrong_cnt_reg;
    timer_next     = timer_reg;
    if (bus.clear) begin
      state_next     = S_OFF;
      wrong_cnt_next = '0;
      timer_next     = '0;
    end else begin
      case (state_reg)
        S_OFF: begin
          if (bus.power_on)
            state_next = (wrong_cnt_reg == '0) ? S_ARMED : S_RETRY;
        end
        S_ARMED, S_RETRY: begin
          // Powering off keeps wrong_cnt so a power cycle cannot reset the tries.
          if (!bus.power_on) begin
            state_next = S_OFF;
          end else if (star_edge) begin
            if (bus.code_ok) begin
              state_next     = S_OPEN;
              wrong_cnt_next = '0;
              timer_next     = T_OPEN;
            end else begin
              wrong_cnt_next = cnt_inc;
              if (cnt_inc == CNT_MAX) begin
                state_next = S_LOCKOUT;
                timer_next = T_LOCK;
              end else begin
                state_next = S_RETRY;
              end
            end
          end
        end
        S_OPEN: begin
          if (!bus.power_on) begin
            state_next = S_OFF;
            timer_next = '0;
          end else if (chg_edge) begin
            state_next = S_CHANGE;
            timer_next = '0;
          end else if (timer_reg <= T_ONE) begin
            state_next = S_ARMED;
            timer_next = '0;
          end else begin
            timer_next = timer_reg - T_ONE;
          end
        end
        S_CHANGE: begin
          if (!bus.power_on)
            state_next = S_OFF;
          else if (star_edge && bus.code_ok)
            state_next = S_OFF;
        end
        S_LOCKOUT: begin
          // Release leaves one try short of the limit, so the next miss relocks.
          if (timer_reg <= T_ONE) begin
            wrong_cnt_next = CNT_RELEASE;
            state_next     = (CNT_RELEASE == '0) ? S_ARMED : S_RETRY;
            timer_next     = '0;
          end else begin
            timer_next = timer_reg - T_ONE;
          end
        end
        default: state_next = S_OFF;
      endcase
    end
  end

  assign bus.state     = state_reg;
  assign bus.wrong_cnt = wrong_cnt_reg;
  assign bus.timer     = timer_reg;
  assign bus.unlock    = unlock_reg;
  assign bus.alarm     = alarm_reg;

endmodule

// File: tb/tb_lock_controller.sv
// Scoreboard bench for lock_controller: stimulus queues the expected status for
// each tick, and a monitor compares the DUT outputs after every tick or reset edge.
module tb_lock_controller;

  localparam int TD = 4;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  lock_controller_if #(.CNT_W(4), .TIMER_W(16)) bus ();

  lock_controller #(
    .TICK_DIV(TD), .MAX_TRIES(3), .CNT_W(4),
    .OPEN_TICKS(3), .LOCK_TICKS(5), .TIMER_W(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  typedef struct {
    string      name;
    logic [2:0] st;
    int         wc;
    int         tm;
  } exp_t;

  exp_t exp_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compares on every reset edge and every tick edge (4th posedge after release).
  initial begin
    exp_t e;
    logic exp_unlock, exp_alarm;
    forever begin
      @(posedge clk);
      if (!rst_n) cyc = 0;
      else        cyc++;
      #1;
      if ((!rst_n || (cyc != 0 && cyc % TD == 0)) && exp_q.size() > 0) begin
        e          = exp_q.pop_front();
        exp_unlock = (e.st == 3'b100);
        exp_alarm  = (e.st == 3'b111);
        checks++;
        if (bus.state !== e.st || int'(bus.wrong_cnt) != e.wc || int'(bus.timer) != e.tm ||
            bus.unlock !== exp_unlock || bus.alarm !== exp_alarm) begin
          errors++;
          $display("FAIL %s: got state=%b wrong_cnt=%0d timer=%0d unlock=%b alarm=%b, expected state=%b wrong_cnt=%0d timer=%0d unlock=%b alarm=%b",
                   e.name, bus.state, bus.wrong_cnt, bus.timer, bus.unlock, bus.alarm,
                   e.st, e.wc, e.tm, exp_unlock, exp_alarm);
        end else begin
          $display("ok   %s: state=%b wrong_cnt=%0d timer=%0d unlock=%b alarm=%b",
                   e.name, bus.state, bus.wrong_cnt, bus.timer, bus.unlock, bus.alarm);
        end
      end
    end
  end

  task automatic do_reset(input string name);
    rst_n = 1'b0;
    exp_q.push_back('{name, 3'b000, 0, 0});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One tick period: apply inputs, queue the status expected after the next tick.
  task automatic t(input string name, input logic s, input logic ok, input logic pw,
                   input logic chg, input logic clr,
                   input logic [2:0] st, input int wc, input int tm);
    bus.star       = s;
    bus.code_ok    = ok;
    bus.power_on   = pw;
    bus.change_req = chg;
    bus.clear      = clr;
    exp_q.push_back('{name, st, wc, tm});
    repeat (TD) @(negedge clk);
  endtask

  // A star pulse that lives only between tick edges must go unnoticed.
  task automatic short_pulse(input string name, input logic [2:0] st, input int wc);
    bus.code_ok = 1'b0;
    exp_q.push_back('{name, st, wc, 0});
    @(negedge clk);
    bus.star = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus.star = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got no end, required end");
    $fatal(1, "timeout");
  end

  initial begin
    bus.power_on = 0; bus.star = 0; bus.change_req = 0; bus.code_ok = 0; bus.clear = 0;
    do_reset("reset");
    //  name          star ok pw chg clr  state  wc tm
    t("power_on",      0, 0, 1, 0, 0, 3'b001, 0, 0);
    t("unlock",        1, 1, 1, 0, 0, 3'b100, 0, 3);
    t("open_t2",       0, 0, 1, 0, 0, 3'b100, 0, 2);
    t("open_t1",       0, 0, 1, 0, 0, 3'b100, 0, 1);
    t("relock",        0, 0, 1, 0, 0, 3'b001, 0, 0);
    t("wrong1",        1, 0, 1, 0, 0, 3'b010, 1, 0);
    t("idle1",         0, 0, 1, 0, 0, 3'b010, 1, 0);
    t("wrong2",        1, 0, 1, 0, 0, 3'b010, 2, 0);
    t("idle2",         0, 0, 1, 0, 0, 3'b010, 2, 0);
    t("wrong3_lock",   1, 0, 1, 0, 0, 3'b111, 3, 5);
    t("lock_t4",       0, 0, 1, 0, 0, 3'b111, 3, 4);
    t("lock_ignore",   1, 1, 0, 0, 0, 3'b111, 3, 3);
    t("lock_t2",       0, 0, 1, 0, 0, 3'b111, 3, 2);
    t("lock_t1",       1, 0, 1, 0, 0, 3'b111, 3, 1);
    t("lock_release",  0, 0, 1, 0, 0, 3'b010, 2, 0);
    t("relock_wrong",  1, 0, 1, 0, 0, 3'b111, 3, 5);
    t("lock2_t4",      0, 0, 1, 0, 0, 3'b111, 3, 4);
    t("clear_lockout", 0, 0, 1, 0, 1, 3'b000, 0, 0);
    t("rearm",         0, 0, 1, 0, 0, 3'b001, 0, 0);
    t("pc_wrong1",     1, 0, 1, 0, 0, 3'b010, 1, 0);
    t("pc_idle1",      0, 0, 1, 0, 0, 3'b010, 1, 0);
    t("pc_wrong2",     1, 0, 1, 0, 0, 3'b010, 2, 0);
    t("pc_idle2",      0, 0, 1, 0, 0, 3'b010, 2, 0);
    t("power_off",     0, 0, 0, 0, 0, 3'b000, 2, 0);
    t("power_back",    0, 0, 1, 0, 0, 3'b010, 2, 0);
    t("pw0_beats_star",1, 0, 0, 0, 0, 3'b000, 2, 0);
    t("power_back2",   0, 0, 1, 0, 0, 3'b010, 2, 0);
    t("clear_retry",   0, 0, 1, 0, 1, 3'b000, 0, 0);
    t("rearm2",        0, 0, 1, 0, 0, 3'b001, 0, 0);
    t("unlock2",       1, 1, 1, 0, 0, 3'b100, 0, 3);
    t("open2_t2",      0, 0, 1, 0, 0, 3'b100, 0, 2);
    t("open2_t1",      0, 0, 1, 0, 0, 3'b100, 0, 1);
    t("chg_beats_exp", 0, 0, 1, 1, 0, 3'b101, 0, 0);
    t("change_bad",    1, 0, 1, 1, 0, 3'b101, 0, 0);
    t("change_idle",   0, 0, 1, 0, 0, 3'b101, 0, 0);
    t("change_commit", 1, 1, 1, 0, 0, 3'b000, 0, 0);
    t("rearm3",        0, 0, 1, 0, 0, 3'b001, 0, 0);
    t("hold_wrong",    1, 0, 1, 0, 0, 3'b010, 1, 0);
    t("hold_2",        1, 0, 1, 0, 0, 3'b010, 1, 0);
    t("hold_3",        1, 0, 1, 0, 0, 3'b010, 1, 0);
    t("hold_release",  0, 0, 1, 0, 0, 3'b010, 1, 0);
    short_pulse("short_pulse", 3'b010, 1);
    t("wrong2_b",      1, 0, 1, 0, 0, 3'b010, 2, 0);
    t("idle_b",        0, 0, 1, 0, 0, 3'b010, 2, 0);
    t("wrong3_b",      1, 0, 1, 0, 0, 3'b111, 3, 5);
    t("lock_b_t4",     0, 0, 1, 0, 0, 3'b111, 3, 4);
    do_reset("reset_mid_lockout");
    t("post_reset",    0, 0, 1, 0, 0, 3'b001, 0, 0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lock_controller.md
# lock_controller

Parametrised successor to the door-lock state manager: a tick-sampled FSM that owns the lock's operating state. It adds a configurable retry limit, a timed lockout with automatic release, and an auto-relock timeout after a successful unlock. It sits between the keypad/comparator front end (`code_ok`, `star`) and the display/actuator logic, which consume `state`, `unlock` and `alarm`.

## Interface
- `TICK_DIV`, 50000: clk cycles per sample tick (≥2).
- `MAX_TRIES`, 3: wrong entries that trigger lockout (1..2^CNT_W-1).
- `CNT_W`, 4: width of `wrong_cnt`.
- `OPEN_TICKS`, 100: ticks in OPEN before auto-relock (≥1).
- `LOCK_TICKS`, 600: ticks in LOCKOUT before release (≥1).
- `TIMER_W`, 16: timer width; must hold max(OPEN_TICKS, LOCK_TICKS).
- `clk` in 1: single clock; all logic on posedge.
- `rst_n` in 1: synchronous, active-low reset.
- `power_on` in 1: level; lock powered/armed request.
- `star` in 1: level; submit key; action on sampled rising edge.
- `change_req` in 1: level; code-change request; action on sampled rising edge.
- `code_ok` in 1: level; entered code matches (in CHANGE: new code length valid).
- `clear` in 1: level; factory initialise.
- `state` out 3: OFF 000, ARMED 001, RETRY 010, OPEN 100, CHANGE 101, LOCKOUT 111.
- `wrong_cnt` out CNT_W: consecutive wrong entries.
- `timer` out TIMER_W: remaining ticks in OPEN/LOCKOUT, else 0.
- `unlock` out 1: high iff state==OPEN (registered).
- `alarm` out 1: high iff state==LOCKOUT (registered).

## Operation
- Divider `div` counts 0..TICK_DIV-1, wraps. A tick is the posedge where div==TICK_DIV-1. FSM, counters and edge registers update only on ticks.
- On each tick, `star_q` <= star and `chg_q` <= change_req. Edge = raw input 1 && *_q 0.
- Priority on a tick, first match wins:
  1. clear=1: OFF, wrong_cnt=0, timer=0.
  2. State 011 (illegal): OFF, counters kept.
  3. OFF: power_on=1 goes to ARMED if wrong_cnt==0, else RETRY.
  4. ARMED/RETRY with power_on=0: OFF. wrong_cnt is retained, so power-cycling cannot clear tries.
  5. ARMED/RETRY with star edge:
     - code_ok=1: OPEN, wrong_cnt=0, timer=OPEN_TICKS.
     - code_ok=0: wrong_cnt+1. If the new value ==MAX_TRIES: LOCKOUT, timer=LOCK_TICKS. Else RETRY.
  6. OPEN:
     - power_on=0: OFF, timer=0.
     - Else change_req edge: CHANGE, timer=0.
     - Else timer==1: ARMED, timer=0.
     - Else timer-1.
  7. CHANGE:
     - power_on=0: OFF.
     - star edge with code_ok=1: OFF (new code committed).
     - star edge with code_ok=0: stay; wrong_cnt untouched.
  8. LOCKOUT: all inputs except clear ignored. At timer==1: wrong_cnt=MAX_TRIES-1, state ARMED if that value is 0, else RETRY, timer=0. Otherwise timer-1.
- wrong_cnt never exceeds MAX_TRIES. Counter and timer arithmetic is unsigned and never wraps.
- Edge registers update on every tick regardless of which branch is taken.

## Timing
- Reset (rst_n=0 at posedge): state=000, wrong_cnt=0, timer=0, unlock=0, alarm=0, div=0, star_q=chg_q=0. Reset mid-operation aborts any timer immediately.
- First tick after reset release: posedge TICK_DIV (counting the first non-reset posedge as 1).
- Latency: state, counters, unlock and alarm change on the tick edge itself. Input pulses shorter than TICK_DIV cycles that do not span a tick edge are missed by design (debounce).
- OPEN lasts exactly OPEN_TICKS ticks. LOCKOUT lasts exactly LOCK_TICKS ticks, unless clear intervenes.
- Simultaneous events: clear beats everything; power_on=0 beats a star edge; change_req edge beats OPEN expiry.

## Test plan
All scenarios use TICK_DIV=4, MAX_TRIES=3, OPEN_TICKS=3, LOCK_TICKS=5.
- Reset, then power_on=1 held: state=001 at posedge 4. Then star edge with code_ok=1: state=100, unlock=1, timer=3. Timer counts 2, 1, then state=001 three ticks after entry.
- Three star edges with code_ok=0: wrong_cnt 1, 2, 3, with state 010, 010, 111 and alarm=1, timer=5. Five ticks later: state=010, wrong_cnt=2. One more wrong entry: state=111 again.
- In 111, star/power_on/code_ok toggled: no change. clear=1: state=000, wrong_cnt=0 on the next tick.
- After two wrong entries, power_on=0 then 1: state 000, then 010, with wrong_cnt still 2.
- In OPEN, change_req edge on the tick where timer==1: state=101, not 001. Star edge with code_ok=0: stays 101. Star edge with code_ok=1: state=000.
- star held high across a tick then kept high: only one wrong_cnt increment. rst_n=0 mid-LOCKOUT: all outputs 0 at that edge.
